// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store data-memory sequencer:
//                RV32I load/store funct3 codes, FSM state type, byte-size
//                masks and small helpers for size, legality and extension.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Byte-lane masks for each access size, before shifting to the offset
    localparam logic [3:0] SZ_MASK_B = 4'b0001;
    localparam logic [3:0] SZ_MASK_H = 4'b0011;
    localparam logic [3:0] SZ_MASK_W = 4'b1111;

    // Byte-lane mask for the access size encoded in funct3
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = SZ_MASK_B;
            F3_H, F3_HU: m = SZ_MASK_H;
            default:     m = SZ_MASK_W;
        endcase
        return m;
    endfunction

    // Access size in bytes; illegal codes are treated as a word so the
    // range check stays conservative
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        logic [2:0] s;
        case (f3)
            F3_B, F3_BU: s = 3'd1;
            F3_H, F3_HU: s = 3'd2;
            default:     s = 3'd4;
        endcase
        return s;
    endfunction

    // Stores have no unsigned variants, so BU/HU are only legal on loads
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Extend right-justified raw load data according to funct3
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {{24{raw[7]}}, raw[7:0]};
            F3_H:    d = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   d = {24'h000000, raw[7:0]};
            F3_HU:   d = {16'h0000, raw[15:0]};
            default: d = raw;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_ctrl_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_byte_lane
//  Description : Combinational byte-lane steering for one memory access
//                phase. Produces the write strobe and lane-aligned write data
//                for either the first (low word) or second (high word) phase
//                of an access, and flags accesses that cross a word boundary.
//  Ports       : i_funct3        access funct3 (selects size)
//                i_offset        byte offset within the word (addr[1:0])
//                i_wdata         right-justified store data
//                i_second_phase  0 = low-word phase, 1 = high-word phase
//                o_strb          byte strobe for this phase
//                o_wdata         lane-aligned write data for this phase
//                o_misaligned    access spans two words
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic        i_second_phase,
    output logic [3:0]  o_strb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    logic [3:0] w_mask;
    logic [2:0] w_size;
    logic [2:0] w_rem;       // bytes of the low word covered: 4 - offset
    logic [3:0] w_strb_lo;
    logic [3:0] w_strb_hi;

    assign w_mask = size_mask(i_funct3);
    assign w_size = size_bytes(i_funct3);
    assign w_rem  = 3'd4 - {1'b0, i_offset};

    // The 4-bit result context drops lanes that spill into the next word;
    // those lanes reappear at the bottom of the second-phase strobe.
    assign w_strb_lo = w_mask << i_offset;
    assign w_strb_hi = w_mask >> w_rem;

    assign o_misaligned = ({1'b0, i_offset} + w_size) > 3'd4;

    always_comb begin
        o_strb  = w_strb_lo;
        o_wdata = i_wdata << {i_offset, 3'b000};
        if (i_second_phase) begin
            o_strb  = w_strb_hi;
            o_wdata = i_wdata >> {w_rem, 3'b000};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dmem_ctrl
//  Description : Load/store sequencer between the MEM pipeline stage and a
//                single-port, byte-strobed data memory. Aligned accesses use
//                one memory cycle; accesses crossing a word boundary are
//                split into two cycles while the pipeline is stalled. Load
//                data is sign/zero-extended, illegal or out-of-range accesses
//                return an error response without touching memory.
//  Ports       : clk, reset (async, active-low)
//                i_req_*   request from MEM stage, o_req_ready = accept
//                o_resp_*  one-cycle completion pulse with load data / error
//                o_mem_*   word-aligned strobed memory port, i_mem_rdata is
//                          combinational read data for o_mem_addr
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = $clog2(DEPTH) + 2,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_strb,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [ADDR_W:0] C_LIMIT = (ADDR_W+1)'(DEPTH * 4);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_we;
    logic [2:0]          r_f3;
    logic [1:0]          r_k;
    logic [31:0]         r_wdata;
    logic [ADDR_W-3:0]   r_word_hi;     // word index of the second phase
    logic [31:0]         r_low;         // low part of a split load
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                w_idle;
    logic                w_ready;
    logic                w_accept;
    logic [2:0]          w_size;
    logic [ADDR_W:0]     w_last;
    logic                w_illegal;
    logic                w_oor;
    logic                w_mis;
    logic                w_err;
    logic                w_go;

    assign w_idle   = (r_state == IDLE);
    // Gating with reset keeps every memory-side output quiet while reset
    // is held, even though the reset itself is asynchronous.
    assign w_ready  = w_idle && reset;
    assign w_accept = w_ready && i_req_valid;

    assign w_size    = size_bytes(i_req_funct3);
    assign w_last    = {1'b0, i_req_addr} + (ADDR_W+1)'(w_size) - (ADDR_W+1)'(1);
    assign w_illegal = !f3_legal(i_req_we, i_req_funct3);
    assign w_oor     = (w_last >= C_LIMIT);
    assign w_err     = w_illegal || w_oor || (w_mis && !MISALIGN_EN);
    assign w_go      = w_accept && !w_err;

    // ------------------------------------------------------------------
    // Byte-lane steering, shared by both phases: live request fields in
    // IDLE, latched fields in SPLIT.
    // ------------------------------------------------------------------
    logic [2:0]  w_lane_f3;
    logic [1:0]  w_lane_k;
    logic [31:0] w_lane_wdata_in;
    logic [3:0]  w_lane_strb;
    logic [31:0] w_lane_wdata;

    assign w_lane_f3       = w_idle ? i_req_funct3    : r_f3;
    assign w_lane_k        = w_idle ? i_req_addr[1:0] : r_k;
    assign w_lane_wdata_in = w_idle ? i_req_wdata     : r_wdata;

    lsu_byte_lane u_lane (
        .i_funct3       (w_lane_f3),
        .i_offset       (w_lane_k),
        .i_wdata        (w_lane_wdata_in),
        .i_second_phase (!w_idle),
        .o_strb         (w_lane_strb),
        .o_wdata        (w_lane_wdata),
        .o_misaligned   (w_mis)
    );

    // ------------------------------------------------------------------
    // Load data alignment
    // ------------------------------------------------------------------
    logic [31:0] w_lo_raw;
    logic [5:0]  w_hi_sh;
    logic [31:0] w_merged;

    assign w_lo_raw = i_mem_rdata >> {i_req_addr[1:0], 3'b000};
    assign w_hi_sh  = {(3'd4 - {1'b0, r_k}), 3'b000};
    assign w_merged = r_low | (i_mem_rdata << w_hi_sh);

    // ------------------------------------------------------------------
    // Memory port: driven combinationally in the accept cycle, or from
    // latched fields during the second phase.
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_strb  = 4'b0000;
        o_mem_wdata = 32'h0000_0000;
        if (w_go) begin
            o_mem_we    = i_req_we;
            o_mem_addr  = {i_req_addr[ADDR_W-1:2], 2'b00};
            o_mem_strb  = i_req_we ? w_lane_strb  : 4'b1111;
            o_mem_wdata = i_req_we ? w_lane_wdata : 32'h0000_0000;
        end else if (!w_idle && reset) begin
            o_mem_we    = r_we;
            o_mem_addr  = {r_word_hi, 2'b00};
            o_mem_strb  = r_we ? w_lane_strb  : 4'b1111;
            o_mem_wdata = r_we ? w_lane_wdata : 32'h0000_0000;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_f3         <= 3'b000;
            r_k          <= 2'b00;
            r_wdata      <= 32'h0000_0000;
            r_word_hi    <= '0;
            r_low        <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_we      <= i_req_we;
                            r_f3      <= i_req_funct3;
                            r_k       <= i_req_addr[1:0];
                            r_wdata   <= i_req_wdata;
                            r_word_hi <= i_req_addr[ADDR_W-1:2] + (ADDR_W-2)'(1);
                            r_low     <= w_lo_raw;
                            if (w_mis) begin
                                r_state <= SPLIT;
                            end else begin
                                r_resp_valid <= 1'b1;
                                r_resp_rdata <= i_req_we ? 32'h0000_0000
                                                         : load_extend(i_req_funct3, w_lo_raw);
                            end
                        end
                    end
                end
                SPLIT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? 32'h0000_0000 : load_extend(r_f3, w_merged);
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = w_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_dmem_ctrl
//  Description : Self-checking bench for lsu_dmem_ctrl. A byte-array model
//                predicts every response; a compare process checks the DUT
//                response port each cycle, and directed vectors pin memory
//                port values and load results to hand-computed literals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_dmem_ctrl;
    import lsu_pkg::*;

    localparam int DEPTH = 128;
    localparam int AW    = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // main DUT (split enabled)
    logic          i_req_valid, i_req_we;
    logic [2:0]    i_req_funct3;
    logic [AW-1:0] i_req_addr;
    logic [31:0]   i_req_wdata;
    logic          o_req_ready, o_resp_valid, o_resp_err, o_mem_we;
    logic [31:0]   o_resp_rdata, o_mem_wdata, mrd;
    logic [AW-1:0] o_mem_addr;
    logic [3:0]    o_mem_strb;

    // second DUT (split disabled)
    logic          n_valid, n_we;
    logic [2:0]    n_f3;
    logic [AW-1:0] n_addr;
    logic [31:0]   n_wd;
    logic          n_ready, n_rv, n_re, n_mwe;
    logic [31:0]   n_rd, n_mwd;
    logic [AW-1:0] n_maddr;
    logic [3:0]    n_strb;
    logic [31:0]   n_mrd = 32'h8000_1234;

    lsu_dmem_ctrl #(.DEPTH(DEPTH), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_strb(o_mem_strb),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mrd)
    );

    lsu_dmem_ctrl #(.DEPTH(DEPTH), .MISALIGN_EN(1'b0)) dut_nm (
        .clk(clk), .reset(reset),
        .i_req_valid(n_valid), .o_req_ready(n_ready), .i_req_we(n_we),
        .i_req_funct3(n_f3), .i_req_addr(n_addr), .i_req_wdata(n_wd),
        .o_resp_valid(n_rv), .o_resp_rdata(n_rd), .o_resp_err(n_re),
        .o_mem_we(n_mwe), .o_mem_addr(n_maddr), .o_mem_strb(n_strb),
        .o_mem_wdata(n_mwd), .i_mem_rdata(n_mrd)
    );

    // data memory behind the main DUT
    logic [31:0] dmem [0:DEPTH-1];
    assign mrd = dmem[o_mem_addr[AW-1:2]];
    always @(posedge clk) begin
        if (o_mem_we) begin
            for (int i = 0; i < 4; i++)
                if (o_mem_strb[i]) dmem[o_mem_addr[AW-1:2]][8*i +: 8] <= o_mem_wdata[8*i +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          split;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [7:0]  mbytes [0:4*DEPTH-1];
    int          ntot = 0;
    int          nbad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference: applies stores, gathers loads little-endian
    task automatic model(input logic we, input logic [2:0] f3, input int addr,
                         input logic [31:0] wd, output exp_t e);
        int          size;
        bit          legal;
        logic [31:0] v;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (we) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
        e.due   = 0;
        e.rdata = 32'h0;
        e.err   = !legal || ((addr + size - 1) >= 4*DEPTH);
        e.split = !e.err && (((addr % 4) + size) > 4);
        if (!e.err && we) begin
            for (int i = 0; i < size; i++) mbytes[addr+i] = wd[8*i +: 8];
        end else if (!e.err) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mbytes[addr+i]) << (8*i));
            if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            e.rdata = v;
        end
    endtask

    // Every cycle: either the predicted response is due, or none may appear
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ce = exp_q.pop_front();
            ntot++;
            if (o_resp_valid !== 1'b1 || o_resp_rdata !== ce.rdata || o_resp_err !== ce.err) begin
                nbad++;
                $display("FAIL resp_model cyc=%0d got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         cyc, o_resp_valid, o_resp_rdata, o_resp_err, ce.rdata, ce.err);
            end
        end else begin
            ntot++;
            if (o_resp_valid !== 1'b0) begin
                nbad++;
                $display("FAIL resp_unexpected cyc=%0d got v=%b want v=0", cyc, o_resp_valid);
            end
        end
    end

    // observations from the last issue() call
    logic [31:0] a_addr, a_wd, b_addr, b_wd, r_d;
    logic [3:0]  a_strb, b_strb;
    logic        a_we, a_rv, b_we, b_ready, r_v, r_e;

    // Called at negedge+1. Presents a request, waits for acceptance, records
    // the memory port in the accept cycle (a_*) and the following cycle
    // (b_*), and the response (r_*). With hold=1 the request stays valid so
    // the caller can present the next one back-to-back.
    task automatic issue(input logic we, input logic [2:0] f3, input int addr,
                         input logic [31:0] wd, input bit hold);
        exp_t e;
        int   guard;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = AW'(addr);
        i_req_wdata  = wd;
        #1;
        guard = 0;
        while (!o_req_ready) begin
            if (guard == 8) begin
                ntot++; nbad++;
                $display("FAIL accept_timeout addr=%h got ready=0 want 1", addr);
                i_req_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
            guard++;
        end
        a_we = o_mem_we; a_addr = 32'(o_mem_addr); a_strb = o_mem_strb;
        a_wd = o_mem_wdata; a_rv = o_resp_valid;
        model(we, f3, addr, wd, e);
        e.due = cyc + 1 + (e.split ? 1 : 0);
        exp_q.push_back(e);
        @(negedge clk); #1;
        if (!hold) i_req_valid = 1'b0;
        b_we = o_mem_we; b_addr = 32'(o_mem_addr); b_strb = o_mem_strb;
        b_wd = o_mem_wdata; b_ready = o_req_ready;
        if (e.split) begin
            @(negedge clk); #1;
        end
        r_v = o_resp_valid; r_d = o_resp_rdata; r_e = o_resp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) dmem[i] = 32'h0;
        for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
        reset        = 1'b0;
        i_req_valid  = 1'b1; i_req_we = 1'b1; i_req_funct3 = F3_W;
        i_req_addr   = 9'h010; i_req_wdata = 32'hDEAD_BEEF;
        n_valid      = 1'b1; n_we = 1'b1; n_f3 = F3_W; n_addr = 9'h010; n_wd = 32'h1;

        // reset held with a pending request: everything stays at zero
        repeat (3) begin
            @(negedge clk); #1;
            chk("reset_outs", 32'($countones({o_req_ready, o_mem_we, o_resp_valid, o_resp_err,
                 o_mem_addr, o_mem_strb, o_mem_wdata, o_resp_rdata,
                 n_ready, n_mwe, n_rv, n_re, n_maddr, n_strb, n_mwd, n_rd})), 32'd0);
        end
        chk("reset_mem_untouched", dmem[4], 32'h0);
        reset = 1'b1; i_req_valid = 1'b0; n_valid = 1'b0;
        @(negedge clk); #1;

        // aligned SW then back-to-back LW
        issue(1'b1, F3_W, 'h10, 32'hDEAD_BEEF, 1'b1);
        chk("sw_strb", 32'(a_strb), 32'hF);
        chk("sw_addr", a_addr, 32'h10);
        chk("sw_we", 32'(a_we), 32'd1);
        chk("sw_wdata", a_wd, 32'hDEAD_BEEF);
        issue(1'b0, F3_W, 'h10, 32'h0, 1'b0);
        chk("b2b_accept_with_resp", 32'(a_rv), 32'd1);
        chk("lw_strb", 32'(a_strb), 32'hF);
        chk("lw_data", r_d, 32'hDEAD_BEEF);

        // sub-word store and extension
        issue(1'b1, F3_B, 'h13, 32'h0000_0081, 1'b0);
        chk("sb_strb", 32'(a_strb), 32'h8);
        chk("sb_wdata", a_wd, 32'h8100_0000);
        chk("sb_addr", a_addr, 32'h10);
        issue(1'b0, F3_B, 'h13, 32'h0, 1'b0);
        chk("lb_data", r_d, 32'hFFFF_FF81);
        issue(1'b0, F3_BU, 'h13, 32'h0, 1'b0);
        chk("lbu_data", r_d, 32'h0000_0081);
        issue(1'b0, F3_H, 'h10, 32'h0, 1'b0);
        chk("lh_data", r_d, 32'hFFFF_BEEF);
        issue(1'b0, F3_HU, 'h12, 32'h0, 1'b0);
        chk("lhu_data", r_d, 32'h0000_81AD);

        // misaligned SW split over 0x0C / 0x10
        issue(1'b1, F3_W, 'h0E, 32'h1122_3344, 1'b0);
        chk("msw_addr0", a_addr, 32'h0C);
        chk("msw_strb0", 32'(a_strb), 32'hC);
        chk("msw_wd0", a_wd, 32'h3344_0000);
        chk("msw_addr1", b_addr, 32'h10);
        chk("msw_strb1", 32'(b_strb), 32'h3);
        chk("msw_wd1", b_wd, 32'h0000_1122);
        chk("msw_we1", 32'(b_we), 32'd1);
        chk("msw_ready1", 32'(b_ready), 32'd0);
        chk("msw_resp", 32'(r_v), 32'd1);
        issue(1'b0, F3_H, 'h0E, 32'h0, 1'b0);
        chk("lh_0e", r_d, 32'h0000_3344);
        issue(1'b0, F3_W, 'h0E, 32'h0, 1'b0);
        chk("mlw_0e", r_d, 32'h1122_3344);
        chk("mlw_strb1", 32'(b_strb), 32'hF);
        issue(1'b0, F3_W, 'h0F, 32'h0, 1'b0);
        chk("mlw_0f", r_d, 32'hAD11_2233);
        issue(1'b0, F3_H, 'h11, 32'h0, 1'b0);
        chk("lh_11", r_d, 32'hFFFF_AD11);
        issue(1'b0, F3_H, 'h13, 32'h0, 1'b0);
        chk("mlh_13", r_d, 32'h0000_0081);

        // errors and range boundary
        issue(1'b0, 3'b011, 'h10, 32'h0, 1'b0);
        chk("err_f3_we", 32'(a_we), 32'd0);
        chk("err_f3_flag", 32'(r_e), 32'd1);
        chk("err_f3_data", r_d, 32'h0);
        issue(1'b1, F3_W, 'h1FE, 32'hCAFE_F00D, 1'b0);
        chk("err_oor_we", 32'(a_we), 32'd0);
        chk("err_oor_flag", 32'(r_e), 32'd1);
        issue(1'b1, F3_BU, 'h20, 32'h55, 1'b0);
        chk("err_sbu_we", 32'(a_we), 32'd0);
        issue(1'b1, F3_B, 'h1FF, 32'h0000_005A, 1'b0);
        chk("edge_sb_err", 32'(r_e), 32'd0);
        issue(1'b0, F3_BU, 'h1FF, 32'h0, 1'b0);
        chk("edge_lbu", r_d, 32'h0000_005A);

        // split disabled: misaligned gives an error, aligned still works
        n_valid = 1'b1; n_we = 1'b0; n_f3 = F3_H; n_addr = 9'h003; #1;
        chk("nm_ready", 32'(n_ready), 32'd1);
        chk("nm_lh03_we", 32'(n_mwe), 32'd0);
        @(negedge clk); #1; n_valid = 1'b0;
        chk("nm_lh03_err", {n_rd[29:0], n_rv, n_re}, 32'h3);
        n_valid = 1'b1; n_addr = 9'h002; #1;
        chk("nm_lh02_strb", 32'(n_strb), 32'hF);
        @(negedge clk); #1; n_valid = 1'b0;
        chk("nm_lh02_data", n_rd, 32'hFFFF_8000);
        chk("nm_lh02_err", 32'(n_re), 32'd0);
        n_valid = 1'b1; n_we = 1'b1; n_f3 = F3_W; n_addr = 9'h005; n_wd = 32'h1234_5678; #1;
        chk("nm_sw05_we", 32'(n_mwe), 32'd0);
        @(negedge clk); #1; n_valid = 1'b0;
        chk("nm_sw05_err", 32'(n_re), 32'd1);

        // reset asserted during the second phase of a split store
        dmem[8] = 32'h0; dmem[9] = 32'hAAAA_AAAA;
        for (int i = 'h24; i < 'h28; i++) mbytes[i] = 8'hAA;
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = F3_W;
        i_req_addr = 9'h022; i_req_wdata = 32'h5566_7788; #1;
        chk("rs_accept", 32'(o_req_ready), 32'd1);
        chk("rs_strb0", 32'(o_mem_strb), 32'hC);
        @(negedge clk); #1;
        i_req_valid = 1'b0;
        chk("rs_split_addr", 32'(o_mem_addr), 32'h24);
        reset = 1'b0; #1;
        chk("rs_we_killed", 32'(o_mem_we), 32'd0);
        @(negedge clk); #1;
        chk("rs_no_resp", 32'(o_resp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rs_word0", dmem[8], 32'h7788_0000);
        chk("rs_word1", dmem[9], 32'hAAAA_AAAA);
        mbytes['h22] = 8'h88; mbytes['h23] = 8'h77;
        issue(1'b0, F3_W, 'h20, 32'h0, 1'b0);
        chk("rs_after_lw0", r_d, 32'h7788_0000);
        issue(1'b0, F3_W, 'h24, 32'h0, 1'b0);
        chk("rs_after_lw1", r_d, 32'hAAAA_AAAA);

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
`default_nettype wire
